// File: rtl/food_arbiter.sv
// food_arbiter: places food inside a legal box away from both snake heads,
// detects eats on frame ticks and keeps two saturating BCD scores.
`timescale 1ns/1ps
module food_arbiter #(
    parameter int FOOD_SIZE       = 4,
    parameter int X_MIN           = 16,
    parameter int X_MAX           = 623,
    parameter int Y_MIN           = 16,
    parameter int Y_MAX           = 463,
    parameter int COOLDOWN_FRAMES = 30,
    parameter int MAX_RETRY       = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [19:0] randCord,
    input  logic [9:0]  snakeX_pos,
    input  logic [9:0]  snakeY_pos,
    input  logic [9:0]  snake2X_pos,
    input  logic [9:0]  snake2Y_pos,
    input  logic [9:0]  snake_size,
    output logic [9:0]  foodX,
    output logic [9:0]  foodY,
    output logic        food_valid,
    output logic        eat1,
    output logic        eat2,
    output logic [7:0]  score1_bcd,
    output logic [7:0]  score2_bcd
);

    localparam logic [9:0] XLO = 10'(X_MIN);
    localparam logic [9:0] XHI = 10'(X_MAX);
    localparam logic [9:0] YLO = 10'(Y_MIN);
    localparam logic [9:0] YHI = 10'(Y_MAX);

    localparam int            CW      = $clog2(COOLDOWN_FRAMES + 2);
    localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN_FRAMES);
    localparam logic [CW-1:0] CD_ONE  = CW'(1);

    localparam logic [4:0] RETRY_LAST = 5'(MAX_RETRY - 1);

    typedef enum logic [1:0] {
        IDLE,
        SPAWN,
        ACTIVE,
        COOLDOWN
    } state_e;

    state_e        state_q;
    logic [2:0]    sync_q;
    logic          tick_q;
    logic [4:0]    retry_q;
    logic [CW-1:0] frames_q;
    logic [9:0]    food_x_q;
    logic [9:0]    food_y_q;
    logic          valid_q;
    logic          eat1_q;
    logic          eat2_q;
    logic [7:0]    score1_q;
    logic [7:0]    score2_q;

    logic [9:0]  cand_x;
    logic [9:0]  cand_y;
    logic [9:0]  clamp_x;
    logic [9:0]  clamp_y;
    logic [10:0] reach;
    logic        cand_in_box;
    logic        cand_free;
    logic        hit1;
    logic        hit2;
    logic [7:0]  score1_d;
    logic [7:0]  score2_d;

    // Differences are taken 11-bit signed so no coordinate pair can wrap.
    function automatic logic overlap(
        input logic [9:0]  ax,
        input logic [9:0]  ay,
        input logic [9:0]  bx,
        input logic [9:0]  by,
        input logic [10:0] lim
    );
        logic signed [10:0] dx;
        logic signed [10:0] dy;
        logic        [10:0] adx;
        logic        [10:0] ady;
        dx  = $signed({1'b0, ax}) - $signed({1'b0, bx});
        dy  = $signed({1'b0, ay}) - $signed({1'b0, by});
        adx = dx[10] ? -dx : dx;
        ady = dy[10] ? -dy : dy;
        return (adx < lim) && (ady < lim);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        if (s == 8'h99) begin
            return s;
        end
        if (s[3:0] == 4'd9) begin
            return {s[7:4] + 4'd1, 4'd0};
        end
        return {s[7:4], s[3:0] + 4'd1};
    endfunction

    always_comb begin
        cand_x      = randCord[19:10];
        cand_y      = randCord[9:0];
        reach       = {1'b0, snake_size} + 11'(FOOD_SIZE);
        cand_in_box = (cand_x >= XLO) && (cand_x <= XHI)
                   && (cand_y >= YLO) && (cand_y <= YHI);
        cand_free   = !overlap(cand_x, cand_y, snakeX_pos, snakeY_pos, reach)
                   && !overlap(cand_x, cand_y, snake2X_pos, snake2Y_pos, reach);
        clamp_x     = (cand_x < XLO) ? XLO : ((cand_x > XHI) ? XHI : cand_x);
        clamp_y     = (cand_y < YLO) ? YLO : ((cand_y > YHI) ? YHI : cand_y);
        hit1        = overlap(food_x_q, food_y_q, snakeX_pos, snakeY_pos, reach);
        hit2        = overlap(food_x_q, food_y_q, snake2X_pos, snake2Y_pos, reach);
        score1_d    = bcd_inc(score1_q);
        score2_d    = bcd_inc(score2_q);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            sync_q   <= '0;
            tick_q   <= 1'b0;
            retry_q  <= '0;
            frames_q <= '0;
            food_x_q <= '0;
            food_y_q <= '0;
            valid_q  <= 1'b0;
            eat1_q   <= 1'b0;
            eat2_q   <= 1'b0;
            score1_q <= '0;
            score2_q <= '0;
        end else begin
            // Two synchronizer flops, then an edge-detect flop for the tick.
            sync_q <= {sync_q[1:0], frame_clk};
            tick_q <= sync_q[1] & ~sync_q[2];
            eat1_q <= 1'b0;
            eat2_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    retry_q <= '0;
                    state_q <= SPAWN;
                end
                SPAWN: begin
                    retry_q <= retry_q + 5'd1;
                    if (cand_in_box && cand_free) begin
                        food_x_q <= cand_x;
                        food_y_q <= cand_y;
                        valid_q  <= 1'b1;
                        state_q  <= ACTIVE;
                    end else if (retry_q == RETRY_LAST) begin
                        food_x_q <= clamp_x;
                        food_y_q <= clamp_y;
                        valid_q  <= 1'b1;
                        state_q  <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (tick_q && (hit1 || hit2)) begin
                        eat1_q   <= hit1;
                        eat2_q   <= hit2;
                        valid_q  <= 1'b0;
                        frames_q <= CD_LOAD;
                        state_q  <= COOLDOWN;
                        if (hit1) begin
                            score1_q <= score1_d;
                        end
                        if (hit2) begin
                            score2_q <= score2_d;
                        end
                    end
                end
                COOLDOWN: begin
                    if (tick_q) begin
                        if (frames_q > CD_ONE) begin
                            frames_q <= frames_q - CD_ONE;
                        end else begin
                            frames_q <= '0;
                            retry_q  <= '0;
                            state_q  <= SPAWN;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign foodX      = food_x_q;
    assign foodY      = food_y_q;
    assign food_valid = valid_q;
    assign eat1       = eat1_q;
    assign eat2       = eat2_q;
    assign score1_bcd = score1_q;
    assign score2_bcd = score2_q;

endmodule

// File: tb/tb_food_arbiter.sv
// tb_food_arbiter: randomized spawn/eat rounds against a queue scoreboard
// fed by a plain-integer reference model of the food rules.
`timescale 1ns/1ps
module tb_food_arbiter;

    localparam int FS  = 4;
    localparam int XLO = 16;
    localparam int XHI = 623;
    localparam int YLO = 16;
    localparam int YHI = 463;
    localparam int CD  = 30;
    localparam int MR  = 16;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic [19:0] randCord = '0;
    logic [9:0]  snakeX_pos = '0;
    logic [9:0]  snakeY_pos = '0;
    logic [9:0]  snake2X_pos = '0;
    logic [9:0]  snake2Y_pos = '0;
    logic [9:0]  snake_size = '0;
    logic [9:0]  foodX;
    logic [9:0]  foodY;
    logic        food_valid;
    logic        eat1;
    logic        eat2;
    logic [7:0]  score1_bcd;
    logic [7:0]  score2_bcd;

    food_arbiter dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .randCord   (randCord),
        .snakeX_pos (snakeX_pos),
        .snakeY_pos (snakeY_pos),
        .snake2X_pos(snake2X_pos),
        .snake2Y_pos(snake2Y_pos),
        .snake_size (snake_size),
        .foodX      (foodX),
        .foodY      (foodY),
        .food_valid (food_valid),
        .eat1       (eat1),
        .eat2       (eat2),
        .score1_bcd (score1_bcd),
        .score2_bcd (score2_bcd)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit is_eat;
        int x;
        int y;
        int lat;
        bit e1;
        bit e2;
        int s1;
        int s2;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   m_s1 = 0;
    int   m_s2 = 0;
    int   fx = 0;
    int   fy = 0;

    task automatic chk(string nm, int act, int want);
        n_chk++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, want);
        end
    endtask

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic bit ovl(int ax, int ay, int bx, int by, int sz);
        return (iabs(ax - bx) < sz + FS) && (iabs(ay - by) < sz + FS);
    endfunction

    function automatic int clampi(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int bcd(int s);
        return (s / 10) * 16 + (s % 10);
    endfunction

    function automatic int near(int f, int sz);
        int lim;
        int off;
        lim = sz + FS;
        off = int'($urandom_range(0, lim - 1));
        if (f >= lim && $urandom_range(0, 1) == 1) return f - off;
        return f + off;
    endfunction

    function automatic int far(int f);
        return (f > 320) ? f - 200 : f + 200;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT shows an eat or a spawn.
    int   since = 0;
    bit   pv = 1'b0;
    int   lx = 0;
    int   ly = 0;
    int   ms1 = 0;
    int   ms2 = 0;
    exp_t me;

    always @(negedge Clk) begin
        if (Reset) begin
            since = 0;
            pv    = 1'b0;
            lx    = 0;
            ly    = 0;
            ms1   = 0;
            ms2   = 0;
        end else begin
            since++;
            if (eat1 || eat2) begin
                if (q.size() == 0 || !q[0].is_eat) begin
                    chk("unexpected_eat", int'(eat1) * 2 + int'(eat2), 0);
                end else begin
                    me = q.pop_front();
                    chk("eat1", int'(eat1), int'(me.e1));
                    chk("eat2", int'(eat2), int'(me.e2));
                    chk("score1", int'(score1_bcd), me.s1);
                    chk("score2", int'(score2_bcd), me.s2);
                    chk("valid_after_eat", int'(food_valid), 0);
                    ms1 = me.s1;
                    ms2 = me.s2;
                end
            end else if (food_valid && !pv) begin
                if (q.size() == 0 || q[0].is_eat) begin
                    chk("unexpected_spawn", 1, 0);
                end else begin
                    me = q.pop_front();
                    chk("spawn_x", int'(foodX), me.x);
                    chk("spawn_y", int'(foodY), me.y);
                    if (me.lat >= 0) chk("spawn_latency", since, me.lat);
                    lx = me.x;
                    ly = me.y;
                end
            end else begin
                if (score1_bcd != 8'(ms1) || score2_bcd != 8'(ms2))
                    chk("score_hold", int'({score1_bcd, score2_bcd}),
                        ms1 * 256 + ms2);
                if (food_valid && (int'(foodX) != lx || int'(foodY) != ly))
                    chk("food_hold", int'(foodX) * 1024 + int'(foodY),
                        lx * 1024 + ly);
            end
            pv = food_valid;
        end
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic tick();
        frame_clk = 1'b1;
        cyc(4);
        frame_clk = 1'b0;
        cyc(4);
    endtask

    task automatic set_heads(int x1, int y1, int x2, int y2, int sz);
        snakeX_pos  = 10'(x1);
        snakeY_pos  = 10'(y1);
        snake2X_pos = 10'(x2);
        snake2Y_pos = 10'(y2);
        snake_size  = 10'(sz);
    endtask

    task automatic push_spawn(int cx, int cy, bit timed);
        exp_t e;
        bit   ok;
        int   sz;
        sz = int'(snake_size);
        ok = cx >= XLO && cx <= XHI && cy >= YLO && cy <= YHI
          && !ovl(cx, cy, int'(snakeX_pos), int'(snakeY_pos), sz)
          && !ovl(cx, cy, int'(snake2X_pos), int'(snake2Y_pos), sz);
        e.is_eat = 1'b0;
        e.x      = ok ? cx : clampi(cx, XLO, XHI);
        e.y      = ok ? cy : clampi(cy, YLO, YHI);
        e.lat    = timed ? (ok ? 3 : 2 + MR) : -1;
        e.e1     = 1'b0;
        e.e2     = 1'b0;
        e.s1     = 0;
        e.s2     = 0;
        fx       = e.x;
        fy       = e.y;
        randCord = {10'(cx), 10'(cy)};
        q.push_back(e);
    endtask

    task automatic prep_spawn(bit timed);
        int cx;
        int cy;
        int mode;
        set_heads(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                  int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                  int'($urandom_range(1, 20)));
        mode = int'($urandom_range(0, 3));
        if (mode <= 1) begin
            cx = int'($urandom_range(XLO, XHI));
            cy = int'($urandom_range(YLO, YHI));
        end else if (mode == 2) begin
            cx = int'($urandom_range(0, 1023));
            cy = int'($urandom_range(0, 1023));
        end else begin
            cx = int'(snakeX_pos);
            cy = int'(snakeY_pos);
        end
        push_spawn(cx, cy, timed);
    endtask

    task automatic wait_valid(string nm);
        int k;
        k = 0;
        while (!food_valid && k < 60) begin
            cyc(1);
            k++;
        end
        chk(nm, int'(food_valid), 1);
        cyc(1);
    endtask

    // Heads are moved first and left still for a few cycles before the tick.
    task automatic fire();
        exp_t e;
        bit   h1;
        bit   h2;
        int   sz;
        cyc(3);
        sz = int'(snake_size);
        h1 = ovl(fx, fy, int'(snakeX_pos), int'(snakeY_pos), sz);
        h2 = ovl(fx, fy, int'(snake2X_pos), int'(snake2Y_pos), sz);
        if (h1 || h2) begin
            if (h1 && m_s1 < 99) m_s1++;
            if (h2 && m_s2 < 99) m_s2++;
            e.is_eat = 1'b1;
            e.x      = 0;
            e.y      = 0;
            e.lat    = -1;
            e.e1     = h1;
            e.e2     = h2;
            e.s1     = bcd(m_s1);
            e.s2     = bcd(m_s2);
            q.push_back(e);
        end
        tick();
    endtask

    task automatic place(bit w1, bit w2);
        int sz;
        sz = int'($urandom_range(1, 20));
        set_heads(w1 ? near(fx, sz) : far(fx), w1 ? near(fy, sz) : far(fy),
                  w2 ? near(fx, sz) : far(fx), w2 ? near(fy, sz) : far(fy), sz);
    endtask

    task automatic cooldown();
        repeat (CD - 1) tick();
        prep_spawn(1'b0);
        tick();
        wait_valid("respawn_after_cooldown");
    endtask

    task automatic reset_hold(int n);
        Reset = 1'b1;
        repeat (n) begin
            cyc(1);
            chk("rst_score1", int'(score1_bcd), 0);
            chk("rst_score2", int'(score2_bcd), 0);
            chk("rst_valid", int'(food_valid), 0);
            chk("rst_eat", int'(eat1) + int'(eat2), 0);
            chk("rst_food", int'(foodX) * 1024 + int'(foodY), 0);
        end
        chk("queue_empty_at_reset", q.size(), 0);
        q.delete();
        m_s1 = 0;
        m_s2 = 0;
    endtask

    initial begin
        reset_hold(3);
        set_heads(400, 400, 400, 400, 8);
        push_spawn(100, 200, 1'b1);
        Reset = 1'b0;
        wait_valid("legal_spawn");

        set_heads(105, 200, 400, 400, 8);
        fire();
        cooldown();
        for (int r = 1; r < 5; r++) begin
            place(1'b1, 1'b0);
            fire();
            if (r < 4) cooldown();
        end
        repeat (10) tick();
        reset_hold(3);
        set_heads(400, 400, 400, 400, 8);
        push_spawn(1000, 5, 1'b1);
        Reset = 1'b0;
        wait_valid("clamped_spawn");

        for (int r = 0; r < 110; r++) begin
            bit w1;
            bit w2;
            if ($urandom_range(0, 2) == 0) begin
                place(1'b0, 1'b0);
                fire();
            end
            w1 = (r < 103) ? 1'b1 : 1'($urandom_range(0, 1));
            w2 = w1 ? 1'($urandom_range(0, 1)) : 1'b1;
            if (r == 20) begin
                set_heads(fx, fy, fx, fy, 8);
            end else begin
                place(w1, w2);
            end
            fire();
            cooldown();
        end

        cyc(10);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/food_arbiter.md
FOOD_ARBITER -- requirements
Module: food_arbiter

Interface
REQ-001 Parameters SHALL be: FOOD_SIZE, 4, food half-width in pixels; X_MIN, 16, X_MAX, 623, Y_MIN, 16, Y_MAX, 463, legal food-centre box; COOLDOWN_FRAMES, 30, frames with no food after an eat; MAX_RETRY, 16, spawn attempts before clamping.
REQ-002 Clk  input  1  system clock (50 MHz); single clock domain.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 frame_clk  input  1  VGA vertical sync; asynchronous to Clk.
REQ-005 randCord  input  20  random coordinate from the SoC; [19:10] = candidate X, [9:0] = candidate Y.
REQ-006 snakeX_pos, snakeY_pos  input  10 each  player-snake head centre.
REQ-007 snake2X_pos, snake2Y_pos  input  10 each  enemy-snake head centre.
REQ-008 snake_size  input  10  snake head half-width, shared by both snakes.
REQ-009 foodX, foodY  output  10 each  current food centre.
REQ-010 food_valid  output  1  high while food is drawn and edible.
REQ-011 eat1, eat2  output  1 each  one-Clk pulse when snake 1 or snake 2 eats the food.
REQ-012 score1_bcd, score2_bcd  output  8 each  two-digit packed BCD score, {tens, ones}.

Function
REQ-013 frame_clk SHALL pass through a 2-flop synchronizer; a rising edge of the synchronized signal SHALL produce frame_tick, one Clk wide, 3 Clk after the input edge.
REQ-014 FSM states SHALL be IDLE, SPAWN, ACTIVE and COOLDOWN.
REQ-015 IDLE SHALL go to SPAWN on the next Clk.
REQ-016 In SPAWN, each Clk SHALL sample randCord as a candidate and increment a 5-bit retry counter.
REQ-017 A SPAWN candidate SHALL be accepted when it lies inside [X_MIN..X_MAX] x [Y_MIN..Y_MAX] and overlaps neither snake head.
- Overlap: |dx| < snake_size+FOOD_SIZE AND |dy| < snake_size+FOOD_SIZE.
- Differences and sums SHALL be computed 11-bit signed with no truncation.
REQ-018 On acceptance, foodX/foodY SHALL be loaded and the FSM SHALL go to ACTIVE; food_valid SHALL be high on the Clk after the accepting cycle.
REQ-019 On the MAX_RETRY-th consecutive rejection, the candidate SHALL be clamped into the legal box and accepted regardless of overlap; the retry counter SHALL clear on every entry to SPAWN.
REQ-020 ACTIVE SHALL evaluate overlap with both heads only on frame_tick; between ticks, head motion SHALL NOT trigger an eat.
REQ-021 An eat SHALL cause all of the following on the next Clk:
- eatN pulses;
- the corresponding score increments;
- food_valid goes low;
- the FSM enters COOLDOWN with the frame counter loaded to COOLDOWN_FRAMES.
REQ-022 When both snakes overlap on the same tick, eat1 and eat2 SHALL both pulse, both scores SHALL increment, and exactly one respawn SHALL follow.
REQ-023 COOLDOWN SHALL decrement on each frame_tick and enter SPAWN on the tick that takes the count to 0; COOLDOWN_FRAMES=0 SHALL give SPAWN on the first tick.
REQ-024 Scores SHALL count in BCD (09 -> 10) and saturate at 99; an eat at 99 SHALL still pulse eatN and respawn.
REQ-025 foodX/foodY SHALL hold their last value outside SPAWN-accept cycles.
REQ-026 frame_tick in IDLE or SPAWN SHALL be ignored.

Reset
REQ-027 On Reset high at a Clk edge, the next state SHALL be:
- FSM in IDLE;
- foodX=foodY=0, food_valid=0, eat1=eat2=0;
- score1_bcd=score2_bcd=8'h00;
- retry counter, frame counter and synchronizer flops at 0.
REQ-028 Reset asserted mid-SPAWN, mid-ACTIVE or mid-COOLDOWN SHALL abort the operation with no eat pulse and no score change.
REQ-029 Reset held over several Clk SHALL keep all outputs at their reset values; SPAWN SHALL begin 1 Clk after Reset falls.

Verification
REQ-030 Legal spawn: Reset, then randCord={10'd100,10'd200}, heads at (400,400), snake_size=8 -> foodX=100, foodY=200, food_valid=1 within 3 Clk of Reset release.
REQ-031 Retry/clamp: randCord held at {10'd1000,10'd5} -> 16 rejections, then foodX=623, foodY=16 accepted, food_valid=1.
REQ-032 Eat: food at (100,200), move snake 1 head to (105,200), size 8, pulse frame_clk -> exactly one eat1 pulse, score1_bcd=8'h01, food_valid=0, respawn after 30 ticks.
REQ-033 Simultaneous eat: both heads at (100,200) on one tick -> eat1 and eat2 in the same Clk, both scores +1, a single SPAWN.
REQ-034 BCD/saturation: 9 eats -> score 8'h09, 10th -> 8'h10; at 8'h99, a further eat keeps 8'h99 and still pulses eat1.
REQ-035 Reset mid-COOLDOWN with score 8'h05 -> score 8'h00, food_valid=0, no eat pulse, normal respawn afterwards.
